vdp_vram_arb: RTL and testbench
===============================

Name: vdp_vram_arb

Overview:
- Arbitrates the single 14-bit VRAM port of vdp_sram between two requesters: the display/sprite fetch engine (DISP) and the CPU VRAM port (CPU).
- DISP has fixed priority. A bounded-wait counter stops display fetches from starving the CPU.
- Sits between vdp_fsm/vdp_cpu and vdp_sram. It drives vdp_sram's req/wr/addr inputs and consumes its ack/rdata.

Parameters:
- CPU_MAX_WAIT, 3: number of consecutive DISP grants allowed while cpu_req is pending; the next grant then goes to CPU. Range 1..15.

Ports:
- clk40m  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- disp_req  in  1  display fetch request; level, held until disp_ack
- disp_addr  in  14  display fetch address (always a read)
- disp_ack  out  1  one-cycle pulse; disp_rdata valid in same cycle
- disp_rdata  out  8  registered read data for DISP
- cpu_req  in  1  CPU access request; level, held until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  14  CPU access address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle pulse; cpu_rdata valid in same cycle (reads)
- cpu_rdata  out  8  registered read data for CPU
- mem_req  out  1  request to vdp_sram; held until mem_ack
- mem_wr  out  1  write strobe qualifier to vdp_sram
- mem_addr  out  14  address to vdp_sram
- mem_wdata  out  8  write data to vdp_sram
- mem_ack  in  1  one-cycle completion pulse from vdp_sram
- mem_rdata  in  8  read data, valid when mem_ack = 1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - All outputs 0, including mem_addr, mem_wdata, disp_rdata and cpu_rdata.
  - Wait counter = 0.
  - mem_req drops immediately. An in-flight access is abandoned and no ack is issued after reset releases.
- States: IDLE, MEM_DISP, MEM_CPU, DONE.
- IDLE:
  - If cpu_req = 1 and (disp_req = 0 or wait_cnt == CPU_MAX_WAIT), go to MEM_CPU.
  - Else if disp_req = 1, go to MEM_DISP.
  - Else stay in IDLE.
  - On the transition, register mem_addr, mem_wr (0 for DISP, cpu_wr for CPU) and mem_wdata (cpu_wdata for CPU, 0 for DISP). Set mem_req = 1.
  - Latency: a request first seen in IDLE at cycle N gives mem_req = 1 in cycle N+1.
- MEM_DISP / MEM_CPU:
  - mem_req, mem_addr, mem_wr and mem_wdata stay stable until mem_ack = 1.
  - On mem_ack = 1: latch mem_rdata into the granted requester's rdata register, drop mem_req, go to DONE.
  - In the DONE cycle, pulse the granted requester's ack for exactly one cycle. Write accesses pulse ack too; rdata is still updated from mem_rdata, and its value after a write is don't-care.
- DONE:
  - Ignores all requests.
  - Clears mem_wr and mem_wdata.
  - Next state is always IDLE.
  - Requesters sample ack at the DONE→IDLE edge and may drop req or present a new request at that edge.
- Throughput: minimum 3 cycles per access (IDLE, MEM with 1-cycle ack, DONE) plus the memory latency.
- wait_cnt (4-bit):
  - Increments on each grant to DISP while cpu_req = 1. Saturates at CPU_MAX_WAIT.
  - Cleared on each grant to CPU, and in any IDLE cycle where cpu_req = 0.
- Simultaneous disp_req and cpu_req in IDLE with wait_cnt < CPU_MAX_WAIT: DISP wins.
- mem_ack arriving in IDLE or DONE is ignored; no state change, no requester ack.
- A requester dropping req before its ack is a protocol violation. The granted access still completes and the ack is still pulsed.
- disp_ack and cpu_ack are never high in the same cycle.
- Neither ack is ever high outside DONE.
- busy = (state != IDLE).

Test Plan:
- Reset mid-access:
  - Stimulus: CPU write granted, mem_req = 1; assert rst_n = 0 before mem_ack; release reset, then pulse mem_ack.
  - Required: mem_req goes 0 asynchronously; all outputs stay 0; no cpu_ack pulse; state = IDLE.
- Single CPU write:
  - Stimulus: cpu_req = 1, cpu_wr = 1, cpu_addr = 14'h1ABC, cpu_wdata = 8'h5A; mem_ack after 2 cycles.
  - Required: cycle N+1 has mem_req = 1, mem_wr = 1, mem_addr = 14'h1ABC, mem_wdata = 8'h5A; cpu_ack pulses 1 cycle after mem_ack; disp_ack stays 0.
- Single DISP read:
  - Stimulus: disp_addr = 14'h0800; mem_ack with mem_rdata = 8'hC3.
  - Required: mem_wr = 0; next cycle disp_ack = 1 and disp_rdata = 8'hC3; busy returns to 0 one cycle later.
- Simultaneous requests:
  - Stimulus: disp_req and cpu_req both rise in the same cycle with wait_cnt = 0.
  - Required: DISP granted first; CPU granted on the following IDLE, provided disp_req is dropped after its ack.
- Starvation bound:
  - Stimulus: disp_req held high continuously, cpu_req high, CPU_MAX_WAIT = 3.
  - Required: grant order is DISP, DISP, DISP, CPU, DISP…; wait_cnt is 0 after the CPU grant.
- Spurious ack:
  - Stimulus: pulse mem_ack while in IDLE.
  - Required: no disp_ack or cpu_ack; rdata registers unchanged; state stays IDLE.

Source files
------------

// File: rtl/vdp_vram_arb.sv
// -----------------------------------------------------------------------------
// vdp_vram_arb
//   Arbitrates the single 14-bit VRAM port of vdp_sram between the display /
//   sprite fetch engine (DISP, fixed priority) and the CPU VRAM port (CPU).
//   A saturating wait counter bounds how many DISP grants may pass a pending
//   CPU request, so the CPU is never starved by back-to-back display fetches.
//
//   Every access takes IDLE -> MEM_DISP/MEM_CPU -> DONE. The grant is decided
//   in IDLE, the memory request is held in MEM_* until mem_ack, and the granted
//   requester sees its one-cycle ack (with registered rdata) in DONE.
//
// Ports
//   clk40m, rst_n           clock, asynchronous active-low reset
//   disp_req/addr           display read request (level, held until disp_ack)
//   disp_ack/rdata          one-cycle completion pulse and read data
//   cpu_req/wr/addr/wdata   CPU access request (level, held until cpu_ack)
//   cpu_ack/rdata           one-cycle completion pulse and read data
//   mem_req/wr/addr/wdata   request to vdp_sram, held until mem_ack
//   mem_ack/rdata           completion pulse and read data from vdp_sram
//   busy                    high whenever an access is in progress
// -----------------------------------------------------------------------------
module vdp_vram_arb #(
    parameter int unsigned CPU_MAX_WAIT = 3
) (
    input  logic        clk40m,
    input  logic        rst_n,
    input  logic        disp_req,
    input  logic [13:0] disp_addr,
    output logic        disp_ack,
    output logic [7:0]  disp_rdata,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [13:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        MEM_DISP,
        MEM_CPU,
        DONE
    } state_t;

    state_t      state_q,      state_d;
    logic [3:0]  wait_cnt_q,   wait_cnt_d;
    logic        mem_req_q,    mem_req_d;
    logic        mem_wr_q,     mem_wr_d;
    logic [13:0] mem_addr_q,   mem_addr_d;
    logic [7:0]  mem_wdata_q,  mem_wdata_d;
    logic        disp_ack_q,   disp_ack_d;
    logic        cpu_ack_q,    cpu_ack_d;
    logic [7:0]  disp_rdata_q, disp_rdata_d;
    logic [7:0]  cpu_rdata_q,  cpu_rdata_d;

    // CPU wins only when DISP is idle or DISP has used up its allowance.
    logic cpu_wins;
    assign cpu_wins = cpu_req && (!disp_req || (wait_cnt_q == MAX_WAIT));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        disp_rdata_d = disp_rdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        // Acks are registered so they are high exactly in the DONE cycle.
        disp_ack_d   = 1'b0;
        cpu_ack_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!cpu_req) begin
                    wait_cnt_d = 4'd0;
                end
                if (cpu_wins) begin
                    state_d     = MEM_CPU;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = cpu_wr;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    wait_cnt_d  = 4'd0;
                end else if (disp_req) begin
                    state_d     = MEM_DISP;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = disp_addr;
                    mem_wdata_d = 8'd0;
                    // Count only the DISP grants that actually made the CPU wait.
                    if (cpu_req && (wait_cnt_q < MAX_WAIT)) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
            end
            MEM_DISP: begin
                if (mem_ack) begin
                    state_d      = DONE;
                    mem_req_d    = 1'b0;
                    disp_rdata_d = mem_rdata;
                    disp_ack_d   = 1'b1;
                end
            end
            MEM_CPU: begin
                if (mem_ack) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    cpu_rdata_d = mem_rdata;
                    cpu_ack_d   = 1'b1;
                end
            end
            DONE: begin
                // Requests are ignored here; requesters update req on this edge.
                state_d     = IDLE;
                mem_wr_d    = 1'b0;
                mem_wdata_d = 8'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk40m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 4'd0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 14'd0;
            mem_wdata_q  <= 8'd0;
            disp_ack_q   <= 1'b0;
            cpu_ack_q    <= 1'b0;
            disp_rdata_q <= 8'd0;
            cpu_rdata_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            disp_ack_q   <= disp_ack_d;
            cpu_ack_q    <= cpu_ack_d;
            disp_rdata_q <= disp_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign disp_ack   = disp_ack_q;
    assign cpu_ack    = cpu_ack_q;
    assign disp_rdata = disp_rdata_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_vdp_vram_arb.sv
// -----------------------------------------------------------------------------
// tb_vdp_vram_arb
//   Directed and randomized bench for vdp_vram_arb. The bench plays both
//   requesters and the SRAM. A transaction-level model predicts each grant
//   from the request levels and a count of DISP grants that passed a waiting
//   CPU; a byte array models VRAM contents for read data.
// -----------------------------------------------------------------------------
module tb_vdp_vram_arb;

    localparam int MAXW = 3;

    logic        clk40m = 1'b0;
    logic        rst_n;
    logic        disp_req, cpu_req, cpu_wr, mem_ack;
    logic [13:0] disp_addr, cpu_addr;
    logic [7:0]  cpu_wdata, mem_rdata;
    logic        disp_ack, cpu_ack, mem_req, mem_wr, busy;
    logic [7:0]  disp_rdata, cpu_rdata, mem_wdata;
    logic [13:0] mem_addr;

    vdp_vram_arb #(.CPU_MAX_WAIT(MAXW)) dut (
        .clk40m    (clk40m),
        .rst_n     (rst_n),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_ack  (disp_ack),
        .disp_rdata(disp_rdata),
        .cpu_req   (cpu_req),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk40m = ~clk40m;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] vram [0:16383];
    int         streak;              // DISP grants that passed a waiting CPU
    logic [7:0] exp_disp_rdata, exp_cpu_rdata;
    int         exp_disp_acks, exp_cpu_acks;
    int         seen_disp_acks, seen_cpu_acks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ack monitor: acks are exclusive, only occur while busy, and are counted.
    always @(negedge clk40m) begin
        if (rst_n && (disp_ack || cpu_ack)) begin
            check("ack_exclusive", 32'(disp_ack & cpu_ack), 0);
            check("ack_only_busy", 32'(busy), 1);
            if (disp_ack) seen_disp_acks++;
            if (cpu_ack)  seen_cpu_acks++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic new_cpu();
        cpu_req   = 1'b1;
        cpu_wr    = 1'($urandom);
        cpu_addr  = 14'($urandom);
        cpu_wdata = 8'($urandom);
    endtask

    task automatic new_disp();
        disp_req  = 1'b1;
        disp_addr = 14'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {31'd0, mem_req}, 0);
        check({tag, "_bus"}, {mem_wr, mem_addr, mem_wdata, disp_ack, cpu_ack, busy}, 0);
        check({tag, "_rdata"}, {16'd0, disp_rdata, cpu_rdata}, 0);
    endtask

    // One complete access. Called at a negedge with requests already set:
    // from_done=1 if the DUT is in DONE now, 0 if it is IDLE.
    task automatic do_access(input int lat, input bit from_done, output bit got_cpu);
        bit         exp_cpu;
        int         n;
        logic [13:0] a;
        logic [7:0]  rd;
        exp_cpu = cpu_req && (!disp_req || streak == MAXW);
        got_cpu = 1'b0;
        n = 0;
        do begin
            @(negedge clk40m);
            n++;
        end while (!mem_req && n < 6);
        check("grant_latency", n, from_done ? 2 : 1);
        if (!mem_req) return;
        a = exp_cpu ? cpu_addr : disp_addr;
        check("mem_addr", 32'(mem_addr), 32'(a));
        check("mem_wr", 32'(mem_wr), exp_cpu ? 32'(cpu_wr) : 0);
        check("mem_wdata", 32'(mem_wdata), exp_cpu ? 32'(cpu_wdata) : 0);
        if (exp_cpu)      streak = 0;
        else if (cpu_req) streak = (streak < MAXW) ? streak + 1 : MAXW;
        else              streak = 0;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk40m);
            check("mem_req_held", {mem_req, disp_ack, cpu_ack, mem_addr}, {3'b100, a});
        end
        rd = (exp_cpu && cpu_wr) ? 8'($urandom) : vram[a];
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk40m);
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        check("cpu_ack", 32'(cpu_ack), 32'(exp_cpu));
        check("disp_ack", 32'(disp_ack), 32'(!exp_cpu));
        check("done_req_busy", {mem_req, busy}, 2'b01);
        if (exp_cpu) begin
            exp_cpu_rdata = rd;
            exp_cpu_acks++;
            if (cpu_wr) vram[a] = cpu_wdata;
            else        check("cpu_rdata", 32'(cpu_rdata), 32'(rd));
        end else begin
            exp_disp_rdata = rd;
            exp_disp_acks++;
            check("disp_rdata", 32'(disp_rdata), 32'(rd));
        end
        got_cpu = cpu_ack;
    endtask

    initial begin
        bit got;
        bit fd;
        rst_n = 1'b0;
        disp_req = 0; disp_addr = 0; cpu_req = 0; cpu_wr = 0;
        cpu_addr = 0; cpu_wdata = 0; mem_ack = 0; mem_rdata = 0;
        streak = 0; exp_disp_rdata = 0; exp_cpu_rdata = 0;
        exp_disp_acks = 0; exp_cpu_acks = 0; seen_disp_acks = 0; seen_cpu_acks = 0;
        for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);

        // Reset state
        repeat (2) @(negedge clk40m);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk40m);

        // Single CPU write
        cpu_req = 1; cpu_wr = 1; cpu_addr = 14'h1ABC; cpu_wdata = 8'h5A;
        do_access(1, 0, got);
        cpu_req = 0;

        // Single DISP read
        vram[14'h0800] = 8'hC3;
        disp_req = 1; disp_addr = 14'h0800;
        do_access(0, 1, got);
        check("disp_read_c3", 32'(disp_rdata), 32'h0C3);
        disp_req = 0;
        @(negedge clk40m);
        check("busy_after_done", {busy, disp_ack}, 0);

        // Simultaneous requests: DISP first, CPU once DISP drops
        @(negedge clk40m);
        new_disp();
        new_cpu();
        do_access(1, 0, got);
        check("simul_first_disp", 32'(got), 0);
        disp_req = 0;
        do_access(0, 1, got);
        check("simul_then_cpu", 32'(got), 1);
        cpu_req = 0;

        // Starvation bound: DISP continuously, CPU pending
        repeat (2) @(negedge clk40m);
        new_disp();
        new_cpu();
        for (int i = 0; i < 8; i++) begin
            do_access(int'($urandom_range(0, 2)), i > 0, got);
            check("starve_order", 32'(got), 32'(i % 4 == 3));
            if (got) new_cpu();
            else     new_disp();
        end
        disp_req = 0;
        cpu_req  = 0;
        repeat (3) @(negedge clk40m);
        streak = 0;

        // Spurious ack in IDLE
        mem_ack = 1; mem_rdata = 8'hEE;
        @(negedge clk40m);
        mem_ack = 0;
        @(negedge clk40m);
        check("spurious_no_ack", {disp_ack, cpu_ack, busy}, 0);
        check("spurious_rdata", {16'd0, disp_rdata, cpu_rdata}, {16'd0, exp_disp_rdata, exp_cpu_rdata});

        // Reset in the middle of a CPU write
        cpu_req = 1; cpu_wr = 1; cpu_addr = 14'($urandom); cpu_wdata = 8'($urandom);
        @(negedge clk40m);
        check("rst_mid_granted", 32'(mem_req), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk40m);
        cpu_req = 0;
        rst_n   = 1'b1;
        streak = 0; exp_disp_rdata = 0; exp_cpu_rdata = 0;
        @(negedge clk40m);
        mem_ack = 1; mem_rdata = 8'h77;
        @(negedge clk40m);
        mem_ack = 0;
        repeat (2) @(negedge clk40m);
        check_all_zero("rst_mid_after");

        // Randomized traffic against the model
        new_disp();
        if ($urandom_range(0, 1) == 1) new_cpu();
        fd = 0;
        for (int k = 0; k < 60; k++) begin
            do_access(int'($urandom_range(0, 3)), fd, got);
            if (got) begin
                if ($urandom_range(0, 1) == 1) new_cpu(); else cpu_req = 0;
            end else begin
                if ($urandom_range(0, 1) == 1) new_disp(); else disp_req = 0;
            end
            if (!disp_req && !cpu_req) begin
                repeat ($urandom_range(1, 3)) @(negedge clk40m);
                streak = 0;
                case ($urandom_range(0, 2))
                    0: new_disp();
                    1: new_cpu();
                    default: begin new_disp(); new_cpu(); end
                endcase
                fd = 0;
            end else begin
                fd = 1;
            end
        end
        disp_req = 0;
        cpu_req  = 0;
        repeat (4) @(negedge clk40m);

        check("disp_ack_count", seen_disp_acks, exp_disp_acks);
        check("cpu_ack_count", seen_cpu_acks, exp_cpu_acks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
